// File: rtl/csr_sched_pkg.sv
// Shared definitions for the CSR sequencer: op encodings, machine CSR
// addresses and the sequencer state enum.
package csr_sched_pkg;

  localparam logic [1:0] CSR_W = 2'b01;
  localparam logic [1:0] CSR_S = 2'b10;
  localparam logic [1:0] CSR_C = 2'b11;

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;
  localparam logic [11:0] CSR_MTVEC  = 12'h305;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    T_EPC   = 3'd1,
    T_CAUSE = 3'd2,
    T_TVAL  = 3'd3,
    T_VEC   = 3'd4,
    R_EPC   = 3'd5
  } csr_sched_state_e;

endpackage

// File: rtl/csr_sched_trap_vec_calc.sv
// Trap target from mtvec: direct mode jumps to base, vectored mode with an
// interrupt cause jumps to base + 4*code.
module trap_vec_calc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mtvec_i,
  input  logic            irq_i,
  input  logic [4:0]      code_i,
  output logic [XLEN-1:0] target_o
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] off;

  // mode bits are stripped from the base; offset wraps modulo 2^XLEN
  always_comb begin
    base = {mtvec_i[XLEN-1:2], 2'b00};
    off  = {{(XLEN-7){1'b0}}, code_i, 2'b00};
    if (mtvec_i[1:0] == 2'b01 && irq_i) target_o = base + off;
    else                                target_o = base;
  end

endmodule

// File: rtl/csr_sched.sv
// Arbiter and trap/mret sequencer in front of the single CSR file port.
// Exec-unit requests pass straight through in IDLE; trap entry and mret
// are serialised into fixed CSR access sequences ending in a done pulse.
module csr_sched
  import csr_sched_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter logic [11:0] MEPC_ADDR   = CSR_MEPC,
  parameter logic [11:0] MCAUSE_ADDR = CSR_MCAUSE,
  parameter logic [11:0] MTVAL_ADDR  = CSR_MTVAL,
  parameter logic [11:0] MTVEC_ADDR  = CSR_MTVEC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [11:0]     inst_a,
  input  logic [XLEN-1:0] inst_d,
  input  logic [1:0]      inst_t,
  output logic [XLEN-1:0] inst_rdata,
  output logic            inst_exists,
  input  logic            trap_valid,
  output logic            trap_ready,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_epc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_valid,
  output logic            mret_ready,
  output logic            done,
  output logic [XLEN-1:0] target,
  output logic            busy,
  output logic            csrfile_valid,
  input  logic            csrfile_ready,
  output logic [11:0]     csrfile_a,
  output logic [XLEN-1:0] csrfile_d,
  output logic [1:0]      csrfile_t,
  input  logic [XLEN-1:0] csrfile_rdata,
  input  logic            csrfile_exists
);

  csr_sched_state_e state_q, state_d;
  logic [XLEN-1:0]  cause_q, cause_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic [XLEN-1:0]  tval_q, tval_d;
  logic [XLEN-1:0]  target_q, target_d;
  logic             done_q, done_d;
  logic [XLEN-1:0]  vec_target;

  trap_vec_calc #(.XLEN(XLEN)) u_vec (
    .mtvec_i  (csrfile_rdata),
    .irq_i    (cause_q[XLEN-1]),
    .code_i   (cause_q[4:0]),
    .target_o (vec_target)
  );

  assign inst_rdata  = csrfile_rdata;
  assign inst_exists = csrfile_exists;
  assign done        = done_q;
  assign target      = target_q;
  assign busy        = (state_q != IDLE);

  // state, latched trap payload and redirect target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cause_q  <= '0;
      epc_q    <= '0;
      tval_q   <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      tval_q   <= tval_d;
      target_q <= target_d;
      done_q   <= done_d;
    end
  end

  // arbitration, CSR port mux and sequence next-state
  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    epc_d         = epc_q;
    tval_d        = tval_q;
    target_d      = target_q;
    done_d        = 1'b0;
    trap_ready    = 1'b0;
    mret_ready    = 1'b0;
    inst_ready    = 1'b0;
    csrfile_valid = 1'b0;
    csrfile_a     = '0;
    csrfile_d     = '0;
    csrfile_t     = '0;
    unique case (state_q)
      IDLE: begin
        trap_ready = 1'b1;
        mret_ready = !trap_valid;
        if (trap_valid) begin
          cause_d = trap_cause;
          epc_d   = trap_epc;
          tval_d  = trap_tval;
          state_d = T_EPC;
        end else if (mret_valid) begin
          state_d = R_EPC;
        end else begin
          // exec unit owns the port with zero added latency
          inst_ready    = csrfile_ready;
          csrfile_valid = inst_valid;
          csrfile_a     = inst_a;
          csrfile_d     = inst_d;
          csrfile_t     = inst_t;
        end
      end
      T_EPC: begin
        csrfile_valid = 1'b1;
        csrfile_a     = MEPC_ADDR;
        csrfile_d     = epc_q;
        csrfile_t     = CSR_W;
        if (csrfile_ready) state_d = T_CAUSE;
      end
      T_CAUSE: begin
        csrfile_valid = 1'b1;
        csrfile_a     = MCAUSE_ADDR;
        csrfile_d     = cause_q;
        csrfile_t     = CSR_W;
        if (csrfile_ready) state_d = T_TVAL;
      end
      T_TVAL: begin
        csrfile_valid = 1'b1;
        csrfile_a     = MTVAL_ADDR;
        csrfile_d     = tval_q;
        csrfile_t     = CSR_W;
        if (csrfile_ready) state_d = T_VEC;
      end
      T_VEC: begin
        // set with zero operand is a pure read of mtvec
        csrfile_valid = 1'b1;
        csrfile_a     = MTVEC_ADDR;
        csrfile_t     = CSR_S;
        if (csrfile_ready) begin
          target_d = vec_target;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      R_EPC: begin
        csrfile_valid = 1'b1;
        csrfile_a     = MEPC_ADDR;
        csrfile_t     = CSR_S;
        if (csrfile_ready) begin
          target_d = {csrfile_rdata[XLEN-1:2], 2'b00};
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_sched.sv
// Directed bench for csr_sched with a small behavioural CSR file behind it.
module tb_csr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid, inst_ready;
  logic [11:0] inst_a;
  logic [31:0] inst_d;
  logic [1:0]  inst_t;
  logic [31:0] inst_rdata;
  logic        inst_exists;
  logic        trap_valid, trap_ready;
  logic [31:0] trap_cause, trap_epc, trap_tval;
  logic        mret_valid, mret_ready;
  logic        done;
  logic [31:0] target;
  logic        busy;
  logic        csrfile_valid, csrfile_ready;
  logic [11:0] csrfile_a;
  logic [31:0] csrfile_d;
  logic [1:0]  csrfile_t;
  logic [31:0] csrfile_rdata;
  logic        csrfile_exists;

  logic [31:0] mem [0:4095];
  logic        pre_en;
  logic [11:0] pre_a;
  logic [31:0] pre_d;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csr_sched dut (
    .clk(clk), .rst(rst),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_a(inst_a),
    .inst_d(inst_d), .inst_t(inst_t), .inst_rdata(inst_rdata),
    .inst_exists(inst_exists),
    .trap_valid(trap_valid), .trap_ready(trap_ready), .trap_cause(trap_cause),
    .trap_epc(trap_epc), .trap_tval(trap_tval),
    .mret_valid(mret_valid), .mret_ready(mret_ready),
    .done(done), .target(target), .busy(busy),
    .csrfile_valid(csrfile_valid), .csrfile_ready(csrfile_ready),
    .csrfile_a(csrfile_a), .csrfile_d(csrfile_d), .csrfile_t(csrfile_t),
    .csrfile_rdata(csrfile_rdata), .csrfile_exists(csrfile_exists)
  );

  // CSR file model: combinational read, write/set/clear on handshake
  assign csrfile_rdata  = mem[csrfile_a];
  assign csrfile_exists = 1'b1;

  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (csrfile_valid && csrfile_ready) begin
      case (csrfile_t)
        2'b01: mem[csrfile_a] <= csrfile_d;
        2'b10: mem[csrfile_a] <= mem[csrfile_a] | csrfile_d;
        2'b11: mem[csrfile_a] <= mem[csrfile_a] & ~csrfile_d;
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one clock and settle away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_req(input string tag, input logic [11:0] a, input logic [31:0] d,
                         input logic [1:0] t);
    chk({tag, ".valid"}, {31'b0, csrfile_valid}, 32'd1);
    chk({tag, ".a"}, {20'b0, csrfile_a}, {20'b0, a});
    chk({tag, ".d"}, csrfile_d, d);
    chk({tag, ".t"}, {30'b0, csrfile_t}, {30'b0, t});
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_a = a; pre_d = d;
    step();
    pre_en = 1'b0;
  endtask

  task automatic start_trap(input logic [31:0] c, input logic [31:0] e, input logic [31:0] v);
    trap_valid = 1'b1; trap_cause = c; trap_epc = e; trap_tval = v;
    #1;
    chk("trap_ready", {31'b0, trap_ready}, 32'd1);
    step();
    // scramble payload to prove it was latched
    trap_valid = 1'b0; trap_cause = 32'hFFFF_FFFF; trap_epc = 32'hFFFF_FFFF; trap_tval = 32'hFFFF_FFFF;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    inst_valid = 0; inst_a = '0; inst_d = '0; inst_t = '0;
    trap_valid = 0; trap_cause = '0; trap_epc = '0; trap_tval = '0;
    mret_valid = 0; csrfile_ready = 1'b1;
    pre_en = 0; pre_a = '0; pre_d = '0;

    // reset state (preloads happen while reset is held)
    preload(12'h305, 32'h8000_0000);
    preload(12'h340, 32'h0000_0055);
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.done", {31'b0, done}, 32'd0);
    chk("rst.target", target, 32'd0);
    chk("rst.valid", {31'b0, csrfile_valid}, 32'd0);
    rst = 1'b0;
    step();

    // pass-through write
    inst_valid = 1; inst_a = 12'h340; inst_d = 32'hDEAD; inst_t = 2'b01;
    #1;
    chk_req("pass", 12'h340, 32'hDEAD, 2'b01);
    chk("pass.ready", {31'b0, inst_ready}, 32'd1);
    chk("pass.rdata", inst_rdata, 32'h55);
    step();
    inst_valid = 0;

    // direct trap
    start_trap(32'd2, 32'h100, 32'h13);
    chk("dt.busy", {31'b0, busy}, 32'd1);
    chk_req("dt.c1", 12'h341, 32'h100, 2'b01); step();
    chk_req("dt.c2", 12'h342, 32'h2, 2'b01);   step();
    chk_req("dt.c3", 12'h343, 32'h13, 2'b01);  step();
    chk_req("dt.c4", 12'h305, 32'h0, 2'b10);
    chk("dt.c4.done", {31'b0, done}, 32'd0);
    step();
    chk("dt.done", {31'b0, done}, 32'd1);
    chk("dt.target", target, 32'h8000_0000);
    chk("dt.idle", {31'b0, busy}, 32'd0);
    step();
    chk("dt.done_once", {31'b0, done}, 32'd0);
    chk("dt.target_hold", target, 32'h8000_0000);

    // vectored interrupt
    preload(12'h305, 32'h8000_0001);
    start_trap(32'h8000_0007, 32'h200, 32'h0);
    for (int i = 0; i < 4; i++) step();
    chk("vi.done", {31'b0, done}, 32'd1);
    chk("vi.target", target, 32'h8000_001C);

    // simultaneous trap / mret / inst
    trap_valid = 1; mret_valid = 1; inst_valid = 1;
    trap_cause = 32'd2; trap_epc = 32'h100; trap_tval = 32'h13;
    inst_a = 12'h340; inst_d = 32'h1; inst_t = 2'b01;
    #1;
    chk("sim.trap_ready", {31'b0, trap_ready}, 32'd1);
    chk("sim.mret_ready", {31'b0, mret_ready}, 32'd0);
    chk("sim.inst_ready", {31'b0, inst_ready}, 32'd0);
    step();
    trap_valid = 0;
    #1;
    chk("sim.busy_mret", {31'b0, mret_ready}, 32'd0);
    chk("sim.busy_inst", {31'b0, inst_ready}, 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("sim.tdone", {31'b0, done}, 32'd1);
    chk("sim.ttarget", target, 32'h8000_0000);
    chk("sim.mret_acc", {31'b0, mret_ready}, 32'd1);
    chk("sim.inst_wait", {31'b0, inst_ready}, 32'd0);
    step();
    mret_valid = 0;
    #1;
    chk_req("sim.repc", 12'h341, 32'h0, 2'b10);
    step();
    chk("sim.mdone", {31'b0, done}, 32'd1);
    chk("sim.mtarget", target, 32'h100);
    chk("sim.inst_go", {31'b0, inst_ready}, 32'd1);
    step();
    inst_valid = 0;

    // stall 3 cycles in T_CAUSE (mtvec still vectored)
    start_trap(32'h8000_0003, 32'h300, 32'h7);
    step();
    csrfile_ready = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_req("st.hold", 12'h342, 32'h8000_0003, 2'b01);
      step();
    end
    csrfile_ready = 1;
    #1;
    chk_req("st.go", 12'h342, 32'h8000_0003, 2'b01);
    step(); step();
    chk("st.nodone", {31'b0, done}, 32'd0);
    step();
    chk("st.done", {31'b0, done}, 32'd1);
    chk("st.target", target, 32'h8000_000C);
    step();

    // reset in T_TVAL, then a fresh trap
    start_trap(32'd2, 32'h400, 32'h9);
    step(); step();
    chk("rs.in_tval", {20'b0, csrfile_a}, 32'h343);
    rst = 1;
    #1;
    chk("rs.busy", {31'b0, busy}, 32'd0);
    chk("rs.valid", {31'b0, csrfile_valid}, 32'd0);
    step();
    rst = 0;
    chk("rs.nodone", {31'b0, done}, 32'd0);
    step();
    chk("rs.nodone2", {31'b0, done}, 32'd0);
    chk("rs.target0", target, 32'd0);
    start_trap(32'd2, 32'h500, 32'h1);
    for (int i = 0; i < 4; i++) step();
    chk("rs.done", {31'b0, done}, 32'd1);
    chk("rs.target", target, 32'h8000_0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/csr_sched.md
Name: csr_sched

Overview:
- Sequencer and arbiter in front of the shared CSR file.
- Three requesters share the single CSR file port:
  - the CSR exec unit (instruction reads, writes, sets, clears);
  - the trap controller (multi-step exception entry);
  - the mret path (return-address fetch).
- Serialises trap entry into a fixed write/read sequence and produces the redirect target for the front end.

Parameters:
XLEN, 32, data width
MEPC_ADDR, 12'h341, mepc address
MCAUSE_ADDR, 12'h342, mcause address
MTVAL_ADDR, 12'h343, mtval address
MTVEC_ADDR, 12'h305, mtvec address

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
inst_valid  in  1  exec-unit CSR request valid
inst_ready  out  1  exec-unit request accepted
inst_a  in  12  exec CSR address
inst_d  in  XLEN  exec operand
inst_t  in  2  op: 01 write, 10 set, 11 clear
inst_rdata  out  XLEN  CSR old value, combinational from csrfile_rdata
inst_exists  out  1  CSR exists, combinational from csrfile_exists
trap_valid  in  1  trap entry request
trap_ready  out  1  trap accepted (payload latched)
trap_cause  in  XLEN  mcause value; bit XLEN-1 = interrupt
trap_epc  in  XLEN  faulting PC
trap_tval  in  XLEN  mtval value
mret_valid  in  1  mret request
mret_ready  out  1  mret accepted
done  out  1  one-cycle pulse: redirect target valid
target  out  XLEN  redirect PC
busy  out  1  sequence in progress (state != IDLE)
csrfile_valid  out  1  request to CSR file
csrfile_ready  in  1  CSR file accepts
csrfile_a  out  12  address
csrfile_d  out  XLEN  operand
csrfile_t  out  2  op
csrfile_rdata  in  XLEN  old value, same cycle as request
csrfile_exists  in  1  address exists

Behaviour:
- Reset:
  - state = IDLE;
  - done = 0, target = 0, busy = 0;
  - latched payload registers = 0.
- States: IDLE, T_EPC, T_CAUSE, T_TVAL, T_VEC, R_EPC.
- Arbitration in IDLE, priority trap > mret > inst:
  - trap_ready = 1 in IDLE.
  - mret_ready = IDLE && !trap_valid.
  - inst_ready = IDLE && !trap_valid && !mret_valid && csrfile_ready.
- Inst pass-through:
  - in IDLE with no trap or mret pending, csrfile_{valid,a,d,t} = inst_valid, inst_a, inst_d, inst_t;
  - zero added latency.
- Trap accept: trap_valid in IDLE latches cause, epc and tval, then moves to T_EPC.
- Trap sequence:
  - T_EPC issues write mepc := epc; T_CAUSE issues write mcause := cause; T_TVAL issues write mtval := tval; T_VEC issues set mtvec with d = 0 (read only).
  - Each step has csrfile_valid = 1 and advances only on csrfile_ready.
- Trap target, computed at the T_VEC handshake and registered:
  - base = rdata with bits [1:0] cleared;
  - if rdata[1:0] == 01 and cause[XLEN-1] = 1: target = base + 4·cause[4:0], modulo 2^XLEN;
  - otherwise target = base.
  - done = 1 the following cycle and state returns to IDLE.
- mret:
  - accepted in IDLE, moves to R_EPC;
  - R_EPC issues set mepc with d = 0;
  - on handshake, target = rdata & ~3, done pulses next cycle, state returns to IDLE.
- Latency with csrfile_ready held high:
  - trap: accept at cycle 0, writes at cycles 1–3, mtvec read at cycle 4, done at cycle 5;
  - mret: accept at cycle 0, read at cycle 1, done at cycle 2.
- Stalls: csrfile_ready low holds the state; csrfile_* outputs stay stable.
- done:
  - exactly one cycle;
  - target holds its value until the next done.
- In IDLE the next request may be accepted in the same cycle that done is high.
- csrfile_exists is ignored outside pass-through; sequence CSRs are mandatory.
- Reset mid-sequence: immediately IDLE, no done pulse, no further csrfile requests.
- inst_valid arriving while busy stays stalled (inst_ready = 0) and is never dropped.

Decomposition:
- Shared package:
  - CSR op encoding (CSR_W = 01, CSR_S = 10, CSR_C = 11);
  - CSR address constants;
  - state enum csr_sched_state_e.
- Sub-module trap_vec_calc (combinational base/vectored target computation) is natural; everything else stays in one module.

Test Plan:
- Inst pass-through: inst write a=0x340, d=0xDEAD, csrfile_ready=1 -> csrfile_a=0x340, csrfile_t=01 in the same cycle, inst_ready=1, inst_rdata equals csrfile_rdata.
- Direct trap: mtvec=0x8000_0000, cause=2, epc=0x100, tval=0x13 -> writes to 0x341/0x342/0x343 with those values at cycles 1–3, read of 0x305 at cycle 4, done at cycle 5, target=0x8000_0000.
- Vectored interrupt: mtvec=0x8000_0001, cause=0x8000_0007 -> target=0x8000_001C.
- Simultaneous requests: trap_valid, mret_valid and inst_valid all high in IDLE -> trap accepted, mret_ready=0, inst_ready=0. After the trap's done, mret is accepted and target=mepc&~3, i.e. the just-written epc (0x100).
- Stall: csrfile_ready low for 3 cycles in T_CAUSE -> outputs stable and done delayed by exactly 3 cycles.
- Reset asserted in T_TVAL -> next cycle busy=0, csrfile_valid=0, no done pulse; a fresh trap then completes normally.
